// File: rtl/icache_line_buffer.sv
// icache_line_buffer_pkg: exception payload returned to fetch.
// icache_line_buffer: fetch-to-ICache interface with an N-entry fully-associative
// line buffer. Hits are served combinationally. One line miss at a time is sent
// to the ICache/TLB, and returned lines fill the buffer with round-robin replacement.
// Flush or a redirect kills the outstanding miss, and its late response is drained.
//   clk_i, rstn_i            clock, async active-low reset
//   fetch_*_i / fetch_*_o    fetch request in, instruction word / exception out
//   flush_i                  invalidate buffer, kill outstanding miss
//   icache_req_* / tlb_req_* miss request (pulse), index / VPN, kill pulse
//   icache_resp_* / tlb_resp_xcpt_i  line return and access fault, ready while awaited
package icache_line_buffer_pkg;
  localparam int unsigned XLEN = 64;

  typedef enum logic [1:0] {
    NONE                  = 2'd0,
    INSTR_ADDR_MISALIGNED = 2'd1,
    INSTR_ACCESS_FAULT    = 2'd2
  } cause_e;

  typedef struct packed {
    cause_e          cause;
    logic [XLEN-1:0] origin;
    logic            valid;
  } exception_t;
endpackage

module icache_line_buffer
  import icache_line_buffer_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 40,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned INST_BITS = 32,
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_BITS  = 12
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          fetch_valid_i,
  input  logic [ADDR_SIZE-1:0]          fetch_vaddr_i,
  input  logic                          flush_i,
  output logic                          icache_req_valid_o,
  output logic [IDX_BITS-1:0]           icache_req_idx_o,
  output logic                          icache_req_kill_o,
  output logic                          tlb_req_valid_o,
  output logic [ADDR_SIZE-IDX_BITS-1:0] tlb_req_vpn_o,
  input  logic                          icache_resp_valid_i,
  input  logic [LINE_BITS-1:0]          icache_resp_data_i,
  output logic                          icache_resp_ready_o,
  input  logic                          tlb_resp_xcpt_i,
  output logic                          fetch_valid_o,
  output logic [INST_BITS-1:0]          fetch_data_o,
  output exception_t                    fetch_ex_o
);

  localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
  localparam int unsigned WOFF   = $clog2(INST_BITS / 8);
  localparam int unsigned TAG_W  = ADDR_SIZE - OFF;
  localparam int unsigned WORDS  = LINE_BITS / INST_BITS;
  localparam int unsigned WSEL_W = OFF - WOFF;
  localparam int unsigned RR_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];

  logic [TAG_W-1:0]                  fetch_tag;
  logic [WSEL_W-1:0]                 word_sel;
  logic                              misaligned;
  logic                              hit;
  logic [LINE_BITS-1:0]              hit_line;
  logic [LINE_BITS-1:0]              sel_line;
  logic [WORDS-1:0][INST_BITS-1:0]   sel_words;
  logic                              miss_match;
  logic                              resp_live;
  logic                              issue;
  logic                              kill;

  assign fetch_tag  = fetch_vaddr_i[ADDR_SIZE-1:OFF];
  assign word_sel   = fetch_vaddr_i[OFF-1:WOFF];
  assign misaligned = |fetch_vaddr_i[1:0];
  assign miss_match = (fetch_tag == miss_tag_q);

  // A response in WAIT is used unless a flush in the same cycle discards it.
  assign resp_live = (state_q == S_WAIT) && icache_resp_valid_i && !flush_i;

  assign issue = (state_q == S_IDLE) && fetch_valid_i && !misaligned && !hit && !flush_i;
  assign kill  = (state_q == S_WAIT) && !icache_resp_valid_i &&
                 (flush_i || (fetch_valid_i && !miss_match));

  // Associative lookup over all valid entries.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == fetch_tag)) begin
        hit      = fetch_valid_i;
        hit_line = data_q[i];
      end
    end
  end

  // Word comes from the hit entry, otherwise from the line being returned.
  assign sel_line  = hit ? hit_line : icache_resp_data_i;
  assign sel_words = sel_line;

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_WAIT;
      S_WAIT: begin
        if (icache_resp_valid_i) state_d = S_IDLE;
        else if (kill)           state_d = S_DRAIN;
      end
      S_DRAIN: if (icache_resp_valid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; misaligned beats hit, hit beats the miss bypass.
  always_comb begin
    icache_req_valid_o  = issue;
    tlb_req_valid_o     = issue;
    icache_req_idx_o    = issue ? fetch_vaddr_i[IDX_BITS-1:0] : '0;
    tlb_req_vpn_o       = issue ? fetch_vaddr_i[ADDR_SIZE-1:IDX_BITS] : '0;
    icache_req_kill_o   = kill;
    icache_resp_ready_o = (state_q != S_IDLE);
    fetch_valid_o       = 1'b0;
    fetch_data_o        = '0;
    fetch_ex_o          = '0;
    fetch_ex_o.cause    = NONE;
    if (fetch_valid_i && misaligned) begin
      fetch_valid_o     = 1'b1;
      fetch_ex_o.valid  = 1'b1;
      fetch_ex_o.cause  = INSTR_ADDR_MISALIGNED;
      fetch_ex_o.origin = XLEN'(fetch_vaddr_i);
    end else if (hit) begin
      fetch_valid_o = 1'b1;
      fetch_data_o  = sel_words[word_sel];
    end else if (fetch_valid_i && resp_live && miss_match) begin
      fetch_valid_o = 1'b1;
      if (tlb_resp_xcpt_i) begin
        fetch_ex_o.valid  = 1'b1;
        fetch_ex_o.cause  = INSTR_ACCESS_FAULT;
        fetch_ex_o.origin = XLEN'(fetch_vaddr_i);
      end else begin
        fetch_data_o = sel_words[word_sel];
      end
    end
  end

  // Buffer and miss-tracking next values; flush beats a same-cycle fill.
  always_comb begin
    valid_d    = valid_q;
    rr_d       = rr_q;
    miss_tag_d = miss_tag_q;
    tag_d      = tag_q;
    data_d     = data_q;
    if (issue) miss_tag_d = fetch_tag;
    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end else if (resp_live && !tlb_resp_xcpt_i) begin
      valid_d[rr_q] = 1'b1;
      tag_d[rr_q]   = miss_tag_q;
      data_d[rr_q]  = icache_resp_data_i;
      rr_d          = (rr_q == RR_W'(NUM_LINES - 1)) ? '0 : rr_q + RR_W'(1);
    end
  end

  // Control flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q    <= '0;
      rr_q       <= '0;
      miss_tag_q <= '0;
    end else begin
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      miss_tag_q <= miss_tag_d;
    end
  end

  // Line storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_LINES; i++) begin
      tag_q[i]  <= tag_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_icache_line_buffer.sv
// Bench for icache_line_buffer: directed vector table, hand-written flush/evict
// sequences, then random traffic against a FIFO-based reference model.
module tb_icache_line_buffer;
  import icache_line_buffer_pkg::*;

  localparam int unsigned AW = 40;
  localparam int unsigned LW = 128;
  localparam int unsigned IW = 32;
  localparam int unsigned NL = 4;
  localparam int unsigned IB = 12;
  localparam int unsigned TW = AW - 4;
  localparam logic [1:0] C_NONE = NONE;
  localparam logic [1:0] C_MIS  = INSTR_ADDR_MISALIGNED;
  localparam logic [1:0] C_FLT  = INSTR_ACCESS_FAULT;

  logic              clk;
  logic              rstn_i;
  logic              fetch_valid_i;
  logic [AW-1:0]     fetch_vaddr_i;
  logic              flush_i;
  logic              icache_req_valid_o;
  logic [IB-1:0]     icache_req_idx_o;
  logic              icache_req_kill_o;
  logic              tlb_req_valid_o;
  logic [AW-IB-1:0]  tlb_req_vpn_o;
  logic              icache_resp_valid_i;
  logic [LW-1:0]     icache_resp_data_i;
  logic              icache_resp_ready_o;
  logic              tlb_resp_xcpt_i;
  logic              fetch_valid_o;
  logic [IW-1:0]     fetch_data_o;
  exception_t        fetch_ex_o;

  int checks = 0;
  int errors = 0;

  icache_line_buffer #(
    .ADDR_SIZE(AW), .LINE_BITS(LW), .INST_BITS(IW), .NUM_LINES(NL), .IDX_BITS(IB)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .fetch_valid_i(fetch_valid_i), .fetch_vaddr_i(fetch_vaddr_i), .flush_i(flush_i),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_idx_o(icache_req_idx_o),
    .icache_req_kill_o(icache_req_kill_o), .tlb_req_valid_o(tlb_req_valid_o),
    .tlb_req_vpn_o(tlb_req_vpn_o), .icache_resp_valid_i(icache_resp_valid_i),
    .icache_resp_data_i(icache_resp_data_i), .icache_resp_ready_o(icache_resp_ready_o),
    .tlb_resp_xcpt_i(tlb_resp_xcpt_i), .fetch_valid_o(fetch_valid_o),
    .fetch_data_o(fetch_data_o), .fetch_ex_o(fetch_ex_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         nm;
    logic          fv;
    logic [AW-1:0] va;
    logic          fl;
    logic          rv;
    logic [LW-1:0] rd;
    logic          xc;
    logic          e_req;
    logic          e_kill;
    logic          e_rdy;
    logic          e_fv;
    logic [IW-1:0] e_data;
    logic          e_exv;
    logic [1:0]    e_cause;
    logic [63:0]   e_org;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [LW-1:0] mkline(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic vec_t mk(input string nm, input logic fv, input logic [AW-1:0] va,
                              input logic fl, input logic rv, input logic [LW-1:0] rd,
                              input logic xc, input logic e_req, input logic e_kill,
                              input logic e_rdy, input logic e_fv, input logic [IW-1:0] e_data,
                              input logic e_exv, input logic [1:0] e_cause,
                              input logic [63:0] e_org);
    vec_t v;
    v.nm = nm; v.fv = fv; v.va = va; v.fl = fl; v.rv = rv; v.rd = rd; v.xc = xc;
    v.e_req = e_req; v.e_kill = e_kill; v.e_rdy = e_rdy; v.e_fv = e_fv;
    v.e_data = e_data; v.e_exv = e_exv; v.e_cause = e_cause; v.e_org = e_org;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle just after posedge, compare at negedge, return to posedge+1.
  task automatic run_vec(input vec_t v);
    fetch_valid_i       = v.fv;
    fetch_vaddr_i       = v.va;
    flush_i             = v.fl;
    icache_resp_valid_i = v.rv;
    icache_resp_data_i  = v.rd;
    tlb_resp_xcpt_i     = v.xc;
    @(negedge clk);
    check({v.nm, ".req"}, 64'(icache_req_valid_o), 64'(v.e_req));
    check({v.nm, ".tlb_req"}, 64'(tlb_req_valid_o), 64'(v.e_req));
    if (v.e_req) begin
      check({v.nm, ".idx"}, 64'(icache_req_idx_o), 64'(v.va[IB-1:0]));
      check({v.nm, ".vpn"}, 64'(tlb_req_vpn_o), 64'(v.va >> IB));
    end
    check({v.nm, ".kill"}, 64'(icache_req_kill_o), 64'(v.e_kill));
    check({v.nm, ".ready"}, 64'(icache_resp_ready_o), 64'(v.e_rdy));
    check({v.nm, ".fvalid"}, 64'(fetch_valid_o), 64'(v.e_fv));
    check({v.nm, ".exv"}, 64'(fetch_ex_o.valid), 64'(v.e_exv));
    check({v.nm, ".cause"}, 64'(fetch_ex_o.cause), 64'(v.e_cause));
    if (v.e_fv) check({v.nm, ".data"}, 64'(fetch_data_o), 64'(v.e_data));
    if (v.e_exv) check({v.nm, ".origin"}, fetch_ex_o.origin, v.e_org);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    run_vec(mk("reset", 0, '0, 0, 0, '0, 0, 0, 0, 0, 0, '0, 0, C_NONE, '0));
    rstn_i = 1'b1;
  endtask

  // Reference model: buffered lines as a map plus insertion order (oldest replaced).
  logic [LW-1:0] m_mem [logic [TW-1:0]];
  logic [TW-1:0] m_order[$];
  bit            m_out;
  bit            m_drain;
  logic [TW-1:0] m_miss;

  function automatic logic [IW-1:0] word_of(input logic [LW-1:0] line, input logic [AW-1:0] va);
    int w;
    w = int'(va[3:2]);
    return line[w*IW +: IW];
  endfunction

  task automatic rand_cycle();
    vec_t          v;
    int            ln;
    logic [TW-1:0] tag;
    bit            mis, hit, bypass;
    ln   = $urandom_range(0, 5);
    v.nm = "rand";
    v.va = AW'(ln * 16 + $urandom_range(0, 3) * 4);
    if (ln % 2 == 1) v.va[AW-1:AW-4] = 4'hA;
    if ($urandom_range(0, 15) == 0) v.va[1:0] = 2'($urandom_range(1, 3));
    v.fv = ($urandom_range(0, 3) != 0);
    v.fl = ($urandom_range(0, 19) == 0);
    v.rv = m_out && ($urandom_range(0, 2) == 0);
    v.xc = v.rv && ($urandom_range(0, 5) == 0);
    v.rd = {$urandom, $urandom, $urandom, $urandom};
    tag  = v.va[AW-1:4];
    mis  = (v.va[1:0] != 2'b00);
    hit  = v.fv && (m_mem.exists(tag) != 0);
    bypass = m_out && !m_drain && v.rv && !v.fl;
    v.e_req  = !m_out && v.fv && !mis && !hit && !v.fl;
    v.e_kill = m_out && !m_drain && !v.rv && (v.fl || (v.fv && tag != m_miss));
    v.e_rdy  = m_out;
    v.e_fv = 0; v.e_data = '0; v.e_exv = 0; v.e_cause = C_NONE; v.e_org = 64'(v.va);
    if (v.fv && mis) begin
      v.e_fv = 1; v.e_exv = 1; v.e_cause = C_MIS;
    end else if (hit) begin
      v.e_fv = 1; v.e_data = word_of(m_mem[tag], v.va);
    end else if (v.fv && bypass && tag == m_miss) begin
      v.e_fv = 1;
      if (v.xc) begin
        v.e_exv = 1; v.e_cause = C_FLT;
      end else begin
        v.e_data = word_of(v.rd, v.va);
      end
    end
    run_vec(v);
    if (v.fl) begin
      m_mem.delete();
      m_order.delete();
    end else if (bypass && !v.xc) begin
      if (m_order.size() == NL) m_mem.delete(m_order.pop_front());
      m_mem[m_miss] = v.rd;
      m_order.push_back(m_miss);
    end
    if (v.e_req) begin
      m_out = 1; m_drain = 0; m_miss = tag;
    end else if (m_out && v.rv) begin
      m_out = 0; m_drain = 0;
    end else if (v.e_kill) begin
      m_drain = 1;
    end
  endtask

  initial begin
    logic [LW-1:0] l1, l2, lz;
    l1 = {32'h4, 32'h3, 32'h2, 32'h1};
    l2 = mkline(32'h200);
    lz = '0;
    rstn_i = 1'b0;
    fetch_valid_i = 0; fetch_vaddr_i = '0; flush_i = 0;
    icache_resp_valid_i = 0; icache_resp_data_i = '0; tlb_resp_xcpt_i = 0;
    #1;
    do_reset();

    // name fv va fl rv rd xc | req kill rdy fv data exv cause origin
    vecs.push_back(mk("idle",       0, 40'h0,    0, 0, lz, 0, 0, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("miss_1000",  1, 40'h1000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("wait1",      1, 40'h1000, 0, 0, lz, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("wait2",      1, 40'h1000, 0, 0, lz, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("resp_1000",  1, 40'h1000, 0, 1, l1, 0, 0, 0, 1, 1, 32'h1,   0, C_NONE, 64'h0));
    vecs.push_back(mk("hit_1004",   1, 40'h1004, 0, 0, lz, 0, 0, 0, 0, 1, 32'h2,   0, C_NONE, 64'h0));
    vecs.push_back(mk("hit_1008",   1, 40'h1008, 0, 0, lz, 0, 0, 0, 0, 1, 32'h3,   0, C_NONE, 64'h0));
    vecs.push_back(mk("hit_100c",   1, 40'h100C, 0, 0, lz, 0, 0, 0, 0, 1, 32'h4,   0, C_NONE, 64'h0));
    vecs.push_back(mk("misal_1002", 1, 40'h1002, 0, 0, lz, 0, 0, 0, 0, 1, 32'h0,   1, C_MIS,  64'h1002));
    vecs.push_back(mk("miss_2000",  1, 40'h2000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("fault_2000", 1, 40'h2000, 0, 1, l2, 1, 0, 0, 1, 1, 32'h0,   1, C_FLT,  64'h2000));
    vecs.push_back(mk("refetch",    1, 40'h2000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("fill_2000",  0, 40'h2000, 0, 1, l2, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("hit_2004",   1, 40'h2004, 0, 0, lz, 0, 0, 0, 0, 1, 32'h201, 0, C_NONE, 64'h0));
    vecs.push_back(mk("hit_nofv",   0, 40'h2004, 0, 0, lz, 0, 0, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    vecs.push_back(mk("misal_nofv", 0, 40'h2003, 0, 0, lz, 0, 0, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Flush in IDLE blocks the request; then five fills evict the oldest line.
    run_vec(mk("flush_idle", 1, 40'h3000, 1, 0, lz, 0, 0, 0, 0, 0, 32'h0, 0, C_NONE, 64'h0));
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] a;
      logic [31:0]   b;
      a = AW'(i * 16);
      b = 32'hA0 + 32'(i * 16);
      run_vec(mk("fill_req",  1, a, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0, 0, C_NONE, 64'h0));
      run_vec(mk("fill_resp", 1, a, 0, 1, mkline(b), 0, 0, 0, 1, 1, b, 0, C_NONE, 64'h0));
    end
    run_vec(mk("hit_14",    1, 40'h14, 0, 0, lz, 0, 0, 0, 0, 1, 32'hB1, 0, C_NONE, 64'h0));
    run_vec(mk("hit_4c",    1, 40'h4C, 0, 0, lz, 0, 0, 0, 0, 1, 32'hE3, 0, C_NONE, 64'h0));
    run_vec(mk("evicted_0", 1, 40'h0,  0, 0, lz, 0, 1, 0, 0, 0, 32'h0,  0, C_NONE, 64'h0));
    run_vec(mk("refill_0",  0, 40'h0,  0, 1, mkline(32'hA0), 0, 0, 0, 1, 0, 32'h0, 0, C_NONE, 64'h0));

    // Flush in WAIT: kill, hit still served, late response discarded.
    run_vec(mk("miss_3000", 1, 40'h3000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("w3000_1",   1, 40'h3000, 0, 0, lz, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("flush_w",   1, 40'h44,   1, 0, lz, 0, 0, 1, 1, 1, 32'hE1,  0, C_NONE, 64'h0));
    run_vec(mk("drain_f",   1, 40'h3000, 0, 0, lz, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("drain_r",   1, 40'h3000, 0, 1, mkline(32'h300), 0, 0, 0, 1, 0, 32'h0, 0, C_NONE, 64'h0));
    run_vec(mk("rereq",     1, 40'h3000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("resp_3000", 1, 40'h3000, 0, 1, mkline(32'h300), 0, 0, 0, 1, 1, 32'h300, 0, C_NONE, 64'h0));
    run_vec(mk("gone_40",   1, 40'h40,   0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("fill_40",   0, 40'h40,   0, 1, mkline(32'hE0), 0, 0, 0, 1, 0, 32'h0, 0, C_NONE, 64'h0));

    // Redirect kill, then flush with a simultaneous response (no kill, no fill).
    run_vec(mk("miss_5000", 1, 40'h5000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("redirect",  1, 40'h5010, 0, 0, lz, 0, 0, 1, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("drain_r2",  0, 40'h5010, 0, 1, lz, 0, 0, 0, 1, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("rereq5",    1, 40'h5000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("flush_rsp", 1, 40'h5000, 1, 1, mkline(32'h500), 0, 0, 0, 1, 0, 32'h0, 0, C_NONE, 64'h0));
    run_vec(mk("nofill",    1, 40'h5000, 0, 0, lz, 0, 1, 0, 0, 0, 32'h0,   0, C_NONE, 64'h0));
    run_vec(mk("fill_5000", 0, 40'h5000, 0, 1, mkline(32'h500), 0, 0, 0, 1, 0, 32'h0, 0, C_NONE, 64'h0));
    run_vec(mk("hit_5008",  1, 40'h5008, 0, 0, lz, 0, 0, 0, 0, 1, 32'h502, 0, C_NONE, 64'h0));

    // Random traffic against the reference model from a fresh reset.
    do_reset();
    m_mem.delete();
    m_order.delete();
    m_out = 0; m_drain = 0; m_miss = '0;
    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
